// File: rtl/dma_arbiter.sv
// OAM DMA engine and SoC bus arbiter: FF46 starts a 160-byte copy from
// {src,00..9F} to FE00..FE9F while the CPU is limited to HRAM and FF46.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | no transfer; CPU bus is passed straight through to the SoC bus
// START | 4-clk startup delay; CPU still passed through
// XFER  | DMA owns the SoC bus, 4 clk per byte; CPU limited to HRAM/FF46
module dma_arbiter (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] cpu_a,
    input  logic [7:0]  cpu_dout,
    output logic [7:0]  cpu_din,
    input  logic        cpu_rd,
    input  logic        cpu_wr,
    output logic [15:0] soc_a,
    output logic [7:0]  soc_dout,
    input  logic [7:0]  soc_din,
    output logic        soc_rd,
    output logic        soc_wr,
    output logic        dma_active
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        START = 2'd1,
        XFER  = 2'd2
    } state_t;

    localparam logic [15:0] DMA_REG   = 16'hFF46;
    localparam logic [7:0]  LAST_IDX  = 8'd159;
    localparam logic [1:0]  START_LEN = 2'd3;

    state_t      state;
    logic [7:0]  src_hi;
    logic [7:0]  src_eff;
    logic [7:0]  idx;
    logic [1:0]  phase;
    logic [1:0]  start_cnt;
    logic [7:0]  latch;
    logic        ff46_hit;
    logic        ff46_wr;
    logic        hram_hit;

    assign ff46_hit = (cpu_a == DMA_REG);
    assign ff46_wr  = ff46_hit && cpu_wr;
    assign hram_hit = (cpu_a[15:7] == 9'h1FF) && (cpu_a != 16'hFFFF);

    // Sources at E0..FF would hit echo RAM; fold them back onto C0..DF.
    assign src_eff = (src_hi >= 8'hE0) ? (src_hi & 8'hDF) : src_hi;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= IDLE;
            src_hi     <= 8'h00;
            idx        <= 8'd0;
            phase      <= 2'd0;
            start_cnt  <= 2'd0;
            latch      <= 8'h00;
            dma_active <= 1'b0;
        end else if (ff46_wr) begin
            // A write to FF46 restarts from any state, even on the final byte.
            state      <= START;
            src_hi     <= cpu_dout;
            idx        <= 8'd0;
            phase      <= 2'd0;
            start_cnt  <= START_LEN;
            dma_active <= 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    dma_active <= 1'b0;
                end
                START: begin
                    if (start_cnt == 2'd0) begin
                        state <= XFER;
                    end else begin
                        start_cnt <= start_cnt - 2'd1;
                    end
                end
                XFER: begin
                    phase <= phase + 2'd1;
                    if (phase == 2'd1) begin
                        latch <= soc_din;
                    end
                    if (phase == 2'd3) begin
                        if (idx == LAST_IDX) begin
                            state      <= IDLE;
                            idx        <= 8'd0;
                            dma_active <= 1'b0;
                        end else begin
                            idx <= idx + 8'd1;
                        end
                    end
                end
                default: begin
                    state      <= IDLE;
                    dma_active <= 1'b0;
                end
            endcase
        end
    end

    always_comb begin
        soc_a    = cpu_a;
        soc_dout = cpu_dout;
        soc_rd   = cpu_rd && !cpu_wr && !ff46_hit;
        soc_wr   = cpu_wr && !ff46_hit;
        cpu_din  = ff46_hit ? src_hi : soc_din;

        if (state == XFER) begin
            // Phases 0-1 read the source, phases 2-3 write OAM.
            soc_a    = phase[1] ? {8'hFE, idx} : {src_eff, idx};
            soc_dout = latch;
            soc_rd   = !phase[1];
            soc_wr   = phase[1];
            if (ff46_hit) begin
                cpu_din = src_hi;
            end else if (hram_hit) begin
                cpu_din = soc_din;
            end else begin
                cpu_din = 8'hFF;
            end
        end

        if (rst) begin
            soc_rd = 1'b0;
            soc_wr = 1'b0;
        end
    end

endmodule

// File: tb/tb_dma_arbiter.sv
// Directed bench for dma_arbiter: a memory model drives soc_din from soc_a,
// and every transfer cycle is checked against the expected bus schedule.
module tb_dma_arbiter;

    logic        clk;
    logic        rst;
    logic [15:0] cpu_a;
    logic [7:0]  cpu_dout;
    logic [7:0]  cpu_din;
    logic        cpu_rd;
    logic        cpu_wr;
    logic [15:0] soc_a;
    logic [7:0]  soc_dout;
    logic [7:0]  soc_din;
    logic        soc_rd;
    logic        soc_wr;
    logic        dma_active;

    int errors = 0;
    int checks = 0;

    dma_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .cpu_a      (cpu_a),
        .cpu_dout   (cpu_dout),
        .cpu_din    (cpu_din),
        .cpu_rd     (cpu_rd),
        .cpu_wr     (cpu_wr),
        .soc_a      (soc_a),
        .soc_dout   (soc_dout),
        .soc_din    (soc_din),
        .soc_rd     (soc_rd),
        .soc_wr     (soc_wr),
        .dma_active (dma_active)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] tb_mem(input logic [15:0] a);
        return a[7:0] ^ a[15:8] ^ 8'h5A;
    endfunction

    always_comb soc_din = tb_mem(soc_a);

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Expected bus state k cycles after the FF46 write edge, CPU idle.
    task automatic probe(input logic [7:0] eff, input int k);
        int          j;
        logic [7:0]  b;
        logic [15:0] ea;
        logic        erd;
        logic        ewr;
        ea  = 16'h0000;
        erd = 1'b0;
        ewr = 1'b0;
        b   = 8'd0;
        if (k >= 4) begin
            j = k - 4;
            b = 8'(j / 4);
            if ((j % 4) < 2) begin
                ea  = {eff, b};
                erd = 1'b1;
            end else begin
                ea  = 16'hFE00 + {8'h00, b};
                ewr = 1'b1;
            end
        end
        check($sformatf("active_k%0d", k), {31'd0, dma_active}, 32'd1);
        check($sformatf("bus_k%0d", k), {14'd0, soc_rd, soc_wr, soc_a}, {14'd0, erd, ewr, ea});
        if (ewr) begin
            check($sformatf("wdata_k%0d", k), {24'd0, soc_dout}, {24'd0, tb_mem({eff, b})});
        end
    endtask

    task automatic run_xfer(input logic [7:0] eff, input int k0, input int k1);
        for (int k = k0; k < k1; k++) begin
            @(negedge clk);
            probe(eff, k);
        end
    endtask

    task automatic check_done(input string tag);
        @(negedge clk);
        check(tag, {29'd0, dma_active, soc_rd, soc_wr}, 32'd0);
    endtask

    task automatic ff46_write(input logic [7:0] d);
        cpu_a    = 16'hFF46;
        cpu_dout = d;
        cpu_wr   = 1'b1;
        @(posedge clk);
        #1;
        cpu_wr   = 1'b0;
        cpu_a    = 16'h0000;
        cpu_dout = 8'h00;
    endtask

    initial begin
        clk      = 1'b0;
        rst      = 1'b1;
        cpu_a    = 16'h1234;
        cpu_dout = 8'h00;
        cpu_rd   = 1'b1;
        cpu_wr   = 1'b0;

        // Reset state, strobes gated even with a CPU read pending
        #2;
        check("rst_active", {31'd0, dma_active}, 32'd0);
        check("rst_strobes", {30'd0, soc_rd, soc_wr}, 32'd0);
        cpu_a = 16'hFF46;
        #1;
        check("rst_ff46_read", {24'd0, cpu_din}, 32'h00);
        cpu_rd = 1'b0;
        cpu_a  = 16'h0000;
        @(negedge clk);
        rst = 1'b0;

        // IDLE transparency on 0x1234
        @(negedge clk);
        cpu_a  = 16'h1234;
        cpu_rd = 1'b1;
        #1;
        check("idle_rd_bus", {14'd0, soc_rd, soc_wr, soc_a}, {14'd0, 2'b10, 16'h1234});
        check("idle_rd_data", {24'd0, cpu_din}, {24'd0, tb_mem(16'h1234)});
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b1;
        cpu_dout = 8'hA5;
        #1;
        check("idle_wr_bus", {14'd0, soc_rd, soc_wr, soc_a}, {14'd0, 2'b01, 16'h1234});
        check("idle_wr_data", {24'd0, soc_dout}, 32'hA5);
        cpu_wr   = 1'b0;
        cpu_a    = 16'h0000;
        cpu_dout = 8'h00;

        // FF46 is local: read returns src_hi, write starts a transfer, neither forwarded
        @(negedge clk);
        cpu_a  = 16'hFF46;
        cpu_rd = 1'b1;
        #1;
        check("ff46_rd_strobes", {30'd0, soc_rd, soc_wr}, 32'd0);
        check("ff46_rd_data", {24'd0, cpu_din}, 32'h00);
        cpu_rd   = 1'b0;
        cpu_wr   = 1'b1;
        cpu_dout = 8'hC1;
        #1;
        check("ff46_wr_strobes", {30'd0, soc_rd, soc_wr}, 32'd0);
        @(posedge clk);
        #1;
        cpu_wr   = 1'b0;
        cpu_a    = 16'h0000;
        cpu_dout = 8'h00;

        // Full 644-clk transfer from 0xC1
        run_xfer(8'hC1, 0, 644);
        check_done("c1_done");

        // Restart mid byte 50 (phase 1) with 0x90
        @(negedge clk);
        ff46_write(8'h80);
        run_xfer(8'h80, 0, 206);
        ff46_write(8'h90);
        run_xfer(8'h90, 0, 644);

        // Restart collides with byte-159 phase-3 write: write completes, START wins
        cpu_a    = 16'hFF46;
        cpu_dout = 8'hF3;
        cpu_wr   = 1'b1;
        #1;
        probe(8'h90, 643);
        @(posedge clk);
        #1;
        cpu_wr   = 1'b0;
        cpu_a    = 16'h0000;
        cpu_dout = 8'h00;
        run_xfer(8'hD3, 0, 644);
        check_done("f3_done");

        // CPU accesses during XFER (k=300 is a read phase)
        @(negedge clk);
        ff46_write(8'hC1);
        run_xfer(8'hC1, 0, 301);
        cpu_a  = 16'h8000;
        cpu_rd = 1'b1;
        #1;
        check("xfer_blocked_rd", {24'd0, cpu_din}, 32'hFF);
        probe(8'hC1, 300);
        cpu_rd   = 1'b0;
        cpu_a    = 16'hC000;
        cpu_dout = 8'hAA;
        cpu_wr   = 1'b1;
        #1;
        check("xfer_blocked_wr", {14'd0, soc_rd, soc_wr, soc_a}, {14'd0, 2'b10, 16'hC14A});
        cpu_wr = 1'b0;
        cpu_a  = 16'hFF90;
        cpu_rd = 1'b1;
        #1;
        check("xfer_hram_rd", {24'd0, cpu_din}, {24'd0, tb_mem(16'hC14A)});
        cpu_a = 16'hFF46;
        #1;
        check("xfer_ff46_rd", {24'd0, cpu_din}, 32'hC1);
        cpu_rd   = 1'b0;
        cpu_a    = 16'h0000;
        cpu_dout = 8'h00;
        run_xfer(8'hC1, 301, 405);

        // Reset at byte 100 aborts immediately
        rst = 1'b1;
        #1;
        check("mid_rst_active", {31'd0, dma_active}, 32'd0);
        check("mid_rst_strobes", {30'd0, soc_rd, soc_wr}, 32'd0);
        cpu_a = 16'hFF46;
        #1;
        check("mid_rst_ff46", {24'd0, cpu_din}, 32'h00);
        cpu_a = 16'h0000;
        @(negedge clk);
        rst = 1'b0;
        check_done("post_rst_idle");

        // First write after reset behaves normally; 0xE5 folds to 0xC5
        @(negedge clk);
        ff46_write(8'hE5);
        run_xfer(8'hC5, 0, 644);
        check_done("e5_done");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/dma_arbiter.md
DMA_ARBITER -- requirements
Module: dma_arbiter

Interface
REQ-001 clk  in  1  SoC clock, 4.19 MHz; all state updates on the rising edge.
REQ-002 rst  in  1  reset, asynchronous, active-high.
REQ-003 cpu_a  in  16  CPU address.
REQ-004 cpu_dout  in  8  CPU write data.
REQ-005 cpu_din  out  8  read data returned to the CPU.
REQ-006 cpu_rd  in  1  CPU read enable.
REQ-007 cpu_wr  in  1  CPU write enable.
REQ-008 soc_a  out  16  SoC bus address.
REQ-009 soc_dout  out  8  SoC bus write data.
REQ-010 soc_din  in  8  SoC bus read data.
REQ-011 soc_rd  out  1  SoC bus read enable.
REQ-012 soc_wr  out  1  SoC bus write enable.
REQ-013 dma_active  out  1  high while an OAM DMA transfer owns the SoC bus.

Function
REQ-014 Register DMA at 0xFF46 SHALL be decoded locally.
- A CPU write latches src_hi = cpu_dout and starts a transfer.
- A CPU read returns src_hi combinationally on cpu_din.
- FF46 accesses SHALL NOT be forwarded: soc_rd = soc_wr = 0.
REQ-015 States: IDLE, START, XFER.
- FF46 write -> START, from any state.
- START -> XFER after exactly 4 clk.
- XFER -> IDLE after byte 159 completes.
REQ-016 dma_active SHALL be 1 in START and XFER, and 0 in IDLE.
REQ-017 XFER moves 160 bytes, idx 0..159 (8-bit counter). Each byte takes 4 clk, phases 0..3 (2-bit counter):
- Phase 0-1: soc_a = {src_eff, idx}, soc_rd = 1; soc_din is captured into a data latch at the end of phase 1.
- Phase 2-3: soc_a = 0xFE00 + idx, soc_dout = latch, soc_wr = 1.
REQ-018 src_eff SHALL equal src_hi, except for src_hi >= 0xE0, where src_eff = src_hi & 0xDF (echo-RAM fold).
REQ-019 A full transfer SHALL take 4 + 640 = 644 clk from the FF46 write edge until dma_active falls.
REQ-020 In IDLE, the arbiter is transparent:
- soc_a/soc_dout/soc_rd/soc_wr = cpu_a/cpu_dout/cpu_rd/cpu_wr.
- cpu_din = soc_din.
REQ-021 In START, CPU access is passed through as in IDLE.
REQ-022 In XFER, CPU accesses to 0xFF80-0xFFFE (HRAM) and 0xFF46 SHALL be passed through (FF46 handled locally), with the following bus priority:
- DMA owns soc_a.
- An HRAM access SHALL use soc_a = cpu_a only in cycles where DMA phase drives no strobe.
- No such cycles exist in XFER, so HRAM is served by a dedicated path: the HRAM strobes and cpu_a are forwarded only when cpu_a[15:7] = 9'h1FF.
- The DMA address is held on soc_a regardless.
REQ-023 In XFER, all other CPU accesses SHALL be blocked:
- Reads return cpu_din = 0xFF.
- Writes are dropped, with no soc_wr from the CPU.
REQ-024 A write to FF46 during START or XFER SHALL restart: src_hi updated, idx = 0, phase = 0, state = START, next edge. Bytes already copied remain in OAM.
REQ-025 If cpu_wr to FF46 and DMA phase 3 of byte 159 occur in the same cycle, the byte-159 write SHALL complete and the restart SHALL win: state = START, not IDLE.
REQ-026 soc_rd and soc_wr SHALL never both be 1 in the same cycle.

Reset
REQ-027 On rst assertion, the block SHALL clear immediately (asynchronous):
- state = IDLE, src_hi = 0x00, idx = 0, phase = 0, latch = 0x00.
- dma_active = 0, soc_rd = 0, soc_wr = 0.
REQ-028 Reset mid-transfer SHALL abort with no further SoC strobes; OAM bytes already written are not restored.
REQ-029 After reset deassertion, the first FF46 write SHALL behave per REQ-015.

Verification
REQ-030 Write 0xC1 to FF46 -> dma_active high for 644 clk; soc reads 0xC100..0xC19F and writes 0xFE00..0xFE9F carry matching data, 4 clk per byte.
REQ-031 Write 0xF3 to FF46 -> reads are sourced from 0xD300..0xD39F.
REQ-032 During XFER:
- CPU reads 0x8000 -> cpu_din = 0xFF.
- CPU writes 0xC000 -> no soc_wr with a = 0xC000.
- CPU reads 0xFF90 -> HRAM data returned.
REQ-033 Write 0x80 at byte 50, then 0x90 -> byte 50 copy stops; a new START (4 clk) follows, then reads from 0x9000; total dma_active = 644 clk after the second write.
REQ-034 Assert rst at byte 100 -> dma_active = 0 and strobes = 0 immediately; reading FF46 returns 0x00.
REQ-035 In IDLE, CPU read/write of 0x1234 -> soc bus mirrors cpu_a/cpu_dout/cpu_rd/cpu_wr and cpu_din = soc_din, same cycle.
